// File: rtl/router_pkg.sv
// Shared definitions for the router write-side controller: widths, the
// reserved header address and the intake FSM state encoding.
package router_pkg;

    localparam int unsigned NUM_PORTS = 3;
    localparam int unsigned ADDR_W    = 2;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    // Select the per-port flag addressed by addr; the reserved address reads as 0.
    function automatic logic port_sel(input logic [NUM_PORTS-1:0] flags,
                                      input logic [ADDR_W-1:0]    addr);
        logic sel;
        case (addr)
            2'd0:    sel = flags[0];
            2'd1:    sel = flags[1];
            2'd2:    sel = flags[2];
            default: sel = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/router_ctrl.sv
// Packet-intake controller: sequences header decode, FIFO-drain wait, payload,
// full-stall and parity phases, and decodes per-phase strobes from the state.
module router_ctrl
    import router_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 write_enb_reg,
    output logic                 rst_int_reg,
    output logic                 busy,
    output logic [ADDR_W-1:0]    cur_dest
);

    state_t state;
    state_t next_state;
    logic   dest_soft_reset;
    logic   hdr_accept;

    assign dest_soft_reset = port_sel(soft_reset, cur_dest);
    assign hdr_accept      = pkt_valid && (data_in != ADDR_INVALID);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= DECODE_ADDRESS;
        end else begin
            state <= next_state;
        end
    end

    // Destination latch: captured on the edge that leaves address decode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_dest <= '0;
        end else if ((state == DECODE_ADDRESS) && (next_state != DECODE_ADDRESS)) begin
            cur_dest <= data_in;
        end
    end

    // Next-state logic; a soft reset of the active destination overrides everything.
    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDRESS: begin
                if (hdr_accept) begin
                    next_state = port_sel(fifo_empty, data_in) ? LOAD_FIRST_DATA
                                                               : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (port_sel(fifo_empty, cur_dest)) begin
                    next_state = LOAD_FIRST_DATA;
                end
            end
            LOAD_FIRST_DATA: begin
                next_state = LOAD_DATA;
            end
            LOAD_DATA: begin
                if (fifo_full) begin
                    next_state = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    next_state = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    next_state = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    next_state = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    next_state = LOAD_PARITY;
                end else begin
                    next_state = LOAD_DATA;
                end
            end
            LOAD_PARITY: begin
                next_state = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: begin
                next_state = DECODE_ADDRESS;
            end
        endcase

        if ((state != DECODE_ADDRESS) && dest_soft_reset) begin
            next_state = DECODE_ADDRESS;
        end
    end

    // Moore output decode from the state register only.
    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b1;
        case (state)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                busy       = 1'b0;
            end
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b0;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_router_ctrl.sv
// Scoreboard bench for router_ctrl: directed stimulus queues the expected
// state/destination after each edge; a negedge monitor pops and compares.
module tb_router_ctrl;
    import router_pkg::*;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 pkt_valid;
    logic [ADDR_W-1:0]    data_in;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic                 fifo_full;
    logic [NUM_PORTS-1:0] soft_reset;
    logic                 parity_done;
    logic                 low_pkt_valid;
    logic                 detect_add, lfd_state, ld_state, laf_state, full_state;
    logic                 write_enb_reg, rst_int_reg, busy;
    logic [ADDR_W-1:0]    cur_dest;

    typedef enum int {S_DA, S_LFD, S_LD, S_FFS, S_LAF, S_LP, S_CPE, S_WTE} tb_st_t;

    typedef struct {
        tb_st_t     st;
        logic [1:0] dest;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    router_ctrl dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .busy(busy), .cur_dest(cur_dest)
    );

    always #5 clock = ~clock;

    // Required strobes {detect_add,lfd,ld,laf,full,write_enb,rst_int,busy} per state.
    function automatic logic [7:0] strobes(input tb_st_t s);
        case (s)
            S_DA:    return 8'b1000_0000;
            S_LFD:   return 8'b0100_0001;
            S_LD:    return 8'b0010_0100;
            S_FFS:   return 8'b0000_1001;
            S_LAF:   return 8'b0001_0101;
            S_LP:    return 8'b0000_0101;
            S_CPE:   return 8'b0000_0011;
            default: return 8'b0000_0001;
        endcase
    endfunction

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [7:0] got;
            e   = exp_q.pop_front();
            got = {detect_add, lfd_state, ld_state, laf_state, full_state,
                   write_enb_reg, rst_int_reg, busy};
            total++;
            if (got !== strobes(e.st) || cur_dest !== e.dest) begin
                bad++;
                $display("FAIL %s: strobes=%b dest=%0d, required strobes=%b dest=%0d (%s)",
                         e.tag, got, cur_dest, strobes(e.st), e.dest, e.st.name());
            end
        end
    end

    task automatic step(input tb_st_t st, input logic [1:0] dest, input string tag);
        exp_t e;
        @(posedge clock);
        e.st = st; e.dest = dest; e.tag = tag;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_empty = 3'b111;
        fifo_full = 1'b0; soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
        step(S_DA, 2'd0, "reset");
        reset = 1'b0;
        step(S_DA, 2'd0, "idle");

        // Header to empty FIFO 1, four payload cycles, parity.
        pkt_valid = 1'b1; data_in = 2'd1;
        step(S_LFD, 2'd1, "hdr1_lfd");
        data_in = 2'd0;
        step(S_LD, 2'd1, "pay1_ld1");
        step(S_LD, 2'd1, "pay1_ld2");
        step(S_LD, 2'd1, "pay1_ld3");
        step(S_LD, 2'd1, "pay1_ld4");
        pkt_valid = 1'b0;
        step(S_LP, 2'd1, "pay1_lp");
        step(S_CPE, 2'd1, "pay1_cpe");
        step(S_DA, 2'd1, "pay1_done");

        // Invalid address is ignored.
        pkt_valid = 1'b1; data_in = 2'd3;
        step(S_DA, 2'd1, "inv_addr1");
        step(S_DA, 2'd1, "inv_addr2");

        // Non-empty destination, then full stall and low_pkt_valid exit.
        data_in = 2'd2; fifo_empty = 3'b011;
        step(S_WTE, 2'd2, "wte_enter");
        data_in = 2'd0;
        step(S_WTE, 2'd2, "wte_hold");
        fifo_empty = 3'b111;
        step(S_LFD, 2'd2, "wte_lfd");
        step(S_LD, 2'd2, "hdr2_ld");
        fifo_full = 1'b1;
        step(S_FFS, 2'd2, "ffs1");
        step(S_FFS, 2'd2, "ffs2");
        step(S_FFS, 2'd2, "ffs3");
        fifo_full = 1'b0;
        step(S_LAF, 2'd2, "laf");
        low_pkt_valid = 1'b1; pkt_valid = 1'b0;
        step(S_LP, 2'd2, "laf_lp");
        low_pkt_valid = 1'b0;
        step(S_CPE, 2'd2, "laf_cpe");
        step(S_DA, 2'd2, "laf_done");

        // Soft reset of another port ignored; own port forces DA.
        pkt_valid = 1'b1; data_in = 2'd0;
        step(S_LFD, 2'd0, "sr_lfd");
        step(S_LD, 2'd0, "sr_ld");
        soft_reset = 3'b010;
        step(S_LD, 2'd0, "sr_other");
        soft_reset = 3'b001;
        step(S_DA, 2'd0, "sr_own");
        soft_reset = 3'b000;

        // fifo_full with !pkt_valid in LD; soft reset beats fifo_full in FFS.
        step(S_LFD, 2'd0, "sim_lfd");
        step(S_LD, 2'd0, "sim_ld");
        pkt_valid = 1'b0; fifo_full = 1'b1;
        step(S_FFS, 2'd0, "full_beats_pv");
        soft_reset = 3'b001;
        step(S_DA, 2'd0, "sr_beats_full");
        soft_reset = 3'b000; fifo_full = 1'b0;

        // LAF->LD, LP->CPE regardless of full, CPE->FFS, LAF parity_done->DA.
        pkt_valid = 1'b1; data_in = 2'd1;
        step(S_LFD, 2'd1, "p3_lfd");
        step(S_LD, 2'd1, "p3_ld");
        fifo_full = 1'b1;
        step(S_FFS, 2'd1, "p3_ffs");
        fifo_full = 1'b0;
        step(S_LAF, 2'd1, "p3_laf");
        step(S_LD, 2'd1, "p3_laf_ld");
        pkt_valid = 1'b0;
        step(S_LP, 2'd1, "p3_lp");
        fifo_full = 1'b1;
        step(S_CPE, 2'd1, "p3_cpe");
        step(S_FFS, 2'd1, "p3_cpe_ffs");
        fifo_full = 1'b0;
        step(S_LAF, 2'd1, "p3_laf2");
        parity_done = 1'b1;
        step(S_DA, 2'd1, "p3_pdone");
        parity_done = 1'b0;

        // Asynchronous reset mid-cycle while in FFS.
        pkt_valid = 1'b1; data_in = 2'd2;
        step(S_LFD, 2'd2, "ar_lfd");
        step(S_LD, 2'd2, "ar_ld");
        fifo_full = 1'b1;
        step(S_FFS, 2'd2, "ar_ffs");
        @(posedge clock);
        #2 reset = 1'b1;
        begin
            exp_t e;
            e.st = S_DA; e.dest = 2'd0; e.tag = "async_reset";
            exp_q.push_back(e);
        end
        @(negedge clock);
        reset = 1'b0; pkt_valid = 1'b0; fifo_full = 1'b0;
        step(S_DA, 2'd0, "post_reset");

        @(posedge clock);
        @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
